pc_mt: RTL and testbench

//  Multi-thread program-counter unit for the fetch stage. Parametrised successor of the single-PC register.

---
 rtl/pc_mt_pkg.sv | 46 ++++
 rtl/pc_mt_rr_arbiter.sv | 26 ++
 rtl/pc_mt.sv | 117 +++++++++++
 tb/tb_pc_mt.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pc_mt_pkg.sv
// Shared types and helpers for the multi-thread program-counter unit.
// The round-robin picker works on a fixed-width vector so one function can serve any thread count.
package pc_mt_pkg;

    typedef enum logic {
        ARB,
        HOLD
    } pc_mt_state_e;

    localparam int MAX_THREADS = 32;
    localparam int MAX_TID_W   = 5;

    function automatic int tid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of en[0..n-1] at or after ptr, wrapping; returns 0 when none is set.
    function automatic logic [MAX_TID_W-1:0] rr_pick(
        input logic [MAX_THREADS-1:0] en,
        input int unsigned            ptr,
        input int unsigned            n
    );
        int unsigned          start;
        int unsigned          idx;
        logic                 found;
        logic [MAX_TID_W-1:0] pick;
        start = (ptr < n) ? ptr : 32'd0;
        found = 1'b0;
        pick  = '0;
        idx   = 32'd0;
        for (int unsigned i = 0; i < MAX_THREADS; i++) begin
            if (i < n) begin
                idx = start + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && en[idx[MAX_TID_W-1:0]]) begin
                    pick  = idx[MAX_TID_W-1:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/pc_mt_rr_arbiter.sv
// Combinational round-robin arbiter; the rotating pointer itself lives in the parent.
module rr_arbiter
    import pc_mt_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = 2
) (
    input  logic [NUM_THREADS-1:0] req,
    input  logic [TID_W-1:0]       ptr,
    output logic [TID_W-1:0]       grant,
    output logic                   any_req
);

    logic [MAX_THREADS-1:0] req_ext;
    logic [MAX_TID_W-1:0]   pick;

    always_comb begin
        req_ext                  = '0;
        req_ext[NUM_THREADS-1:0] = req;
        pick                     = rr_pick(req_ext, 32'(ptr), NUM_THREADS);
    end

    assign grant   = TID_W'(pick);
    assign any_req = |req;

endmodule

// File: rtl/pc_mt.sv
// Multi-thread program counter for fetch: round-robin thread pick, valid/ready offer to imem,
// per-thread redirect and exception vectoring.
module pc_mt
    import pc_mt_pkg::*;
#(
    parameter int                NUM_THREADS  = 4,
    parameter int                ADDR_W       = 32,
    parameter int                INSTR_BYTES  = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = 32'h8000_0180,
    localparam int               TID_W        = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_THREADS-1:0] thread_en,
    input  logic                   stall,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [TID_W-1:0]       req_tid,
    output logic [ADDR_W-1:0]      pc_out,
    output logic [ADDR_W-1:0]      next_pc,
    input  logic                   redir_valid,
    input  logic [TID_W-1:0]       redir_tid,
    input  logic [ADDR_W-1:0]      redir_target,
    input  logic                   exc_valid,
    input  logic [TID_W-1:0]       exc_tid,
    output logic                   misalign
);

    localparam logic [ADDR_W-1:0] INC      = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);

    pc_mt_state_e      state_q;
    logic [TID_W-1:0]  rr_q;
    logic [TID_W-1:0]  lock_q;
    logic [ADDR_W-1:0] pc_q [NUM_THREADS];
    logic              misalign_q;

    logic [TID_W-1:0]  arb_grant;
    logic              arb_any;
    logic [TID_W-1:0]  sel;
    logic [TID_W-1:0]  rr_next;
    logic              accept;
    logic              redir_applied;

    rr_arbiter #(
        .NUM_THREADS(NUM_THREADS),
        .TID_W      (TID_W)
    ) u_arb (
        .req    (thread_en),
        .ptr    (rr_q),
        .grant  (arb_grant),
        .any_req(arb_any)
    );

    // A held offer ignores stall and thread_en until imem takes it.
    always_comb begin
        sel       = (state_q == HOLD) ? lock_q : arb_grant;
        req_valid = !reset && ((state_q == HOLD) || (arb_any && !stall));
        accept    = req_valid && req_ready;
        rr_next   = (sel == TID_W'(NUM_THREADS - 1)) ? '0 : sel + 1'b1;
        req_tid   = sel;
        pc_out    = pc_q[sel];
        next_pc   = pc_q[sel] + INC;
        misalign  = misalign_q;
    end

    // A redirect loses to an exception on the same thread, so it cannot flag misalignment then.
    assign redir_applied = redir_valid
                        && (int'(redir_tid) < NUM_THREADS)
                        && !(exc_valid && (exc_tid == redir_tid));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB;
            rr_q       <= '0;
            lock_q     <= '0;
            misalign_q <= 1'b0;
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= RESET_VECTOR;
            end
        end else begin
            misalign_q <= redir_applied && (|(redir_target & LOW_MASK));

            for (int t = 0; t < NUM_THREADS; t++) begin
                if (exc_valid && (exc_tid == TID_W'(t))) begin
                    pc_q[t] <= EXC_VECTOR;
                end else if (redir_valid && (redir_tid == TID_W'(t))) begin
                    pc_q[t] <= redir_target & ~LOW_MASK;
                end else if (accept && (sel == TID_W'(t))) begin
                    pc_q[t] <= pc_q[t] + INC;
                end
            end

            case (state_q)
                ARB: begin
                    if (req_valid) begin
                        if (req_ready) begin
                            rr_q <= rr_next;
                        end else begin
                            lock_q  <= sel;
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (req_ready) begin
                        rr_q    <= rr_next;
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_mt.sv
// Directed bench for pc_mt: each step drives one cycle of inputs and queues the outputs expected that cycle.
module tb_pc_mt;

    localparam logic [31:0] EXC = 32'h8000_0180;

    logic        clk;
    logic        reset;
    logic [3:0]  thread_en;
    logic        stall;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_tid;
    logic [31:0] pc_out;
    logic [31:0] next_pc;
    logic        redir_valid;
    logic [1:0]  redir_tid;
    logic [31:0] redir_target;
    logic        exc_valid;
    logic [1:0]  exc_tid;
    logic        misalign;

    typedef struct {
        logic        full;
        logic        valid;
        logic [1:0]  tid;
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    pc_mt dut (
        .clk         (clk),
        .reset       (reset),
        .thread_en   (thread_en),
        .stall       (stall),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_tid     (req_tid),
        .pc_out      (pc_out),
        .next_pc     (next_pc),
        .redir_valid (redir_valid),
        .redir_tid   (redir_tid),
        .redir_target(redir_target),
        .exc_valid   (exc_valid),
        .exc_tid     (exc_tid),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] en, input logic st, input logic rdy,
                                 input logic rv, input logic [1:0] rt, input logic [31:0] rtgt,
                                 input logic ev, input logic [1:0] et);
        @(negedge clk);
        reset        = rst;
        thread_en    = en;
        stall        = st;
        req_ready    = rdy;
        redir_valid  = rv;
        redir_tid    = rt;
        redir_target = rtgt;
        exc_valid    = ev;
        exc_tid      = et;
    endtask

    task automatic pushExpect(input logic full, input logic v, input logic [1:0] tid,
                              input logic [31:0] pc, input logic mis);
        exp_t e;
        e.full  = full;
        e.valid = v;
        e.tid   = tid;
        e.pc    = pc;
        e.mis   = mis;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            cmp("req_valid", 32'(req_valid), 32'(e.valid));
            cmp("misalign", 32'(misalign), 32'(e.mis));
            if (e.full) begin
                cmp("req_tid", 32'(req_tid), 32'(e.tid));
                cmp("pc_out", pc_out, e.pc);
                cmp("next_pc", next_pc, e.pc + 32'd4);
            end
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] en, input logic st, input logic rdy,
                        input logic full, input logic v, input logic [1:0] tid,
                        input logic [31:0] pc, input logic mis);
        applyStimulus(rst, en, st, rdy, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0);
        pushExpect(full, v, tid, pc, mis);
        checkOutput();
    endtask

    task automatic stepEvt(input logic [3:0] en, input logic st, input logic rdy,
                           input logic rv, input logic [1:0] rt, input logic [31:0] rtgt,
                           input logic ev, input logic [1:0] et,
                           input logic full, input logic v, input logic [1:0] tid,
                           input logic [31:0] pc, input logic mis);
        applyStimulus(1'b0, en, st, rdy, rv, rt, rtgt, ev, et);
        pushExpect(full, v, tid, pc, mis);
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        thread_en    = 4'b0000;
        stall        = 1'b0;
        req_ready    = 1'b0;
        redir_valid  = 1'b0;
        redir_tid    = 2'd0;
        redir_target = 32'd0;
        exc_valid    = 1'b0;
        exc_tid      = 2'd0;

        // Reset holds req_valid low even with every thread enabled.
        step(1, 4'b1111, 0, 1, 0, 0, 0, 0, 0);
        step(1, 4'b1111, 0, 1, 0, 0, 0, 0, 0);

        $display("[TB] all threads enabled, ready every cycle");
        step(0, 4'b1111, 0, 1, 1, 1, 2'd0, 32'h0, 0);
        step(0, 4'b1111, 0, 1, 1, 1, 2'd1, 32'h0, 0);
        step(0, 4'b1111, 0, 1, 1, 1, 2'd2, 32'h0, 0);
        step(0, 4'b1111, 0, 1, 1, 1, 2'd3, 32'h0, 0);
        step(0, 4'b1111, 0, 1, 1, 1, 2'd0, 32'h4, 0);

        $display("[TB] sparse enable 1010");
        step(1, 4'b1111, 0, 1, 0, 0, 0, 0, 0);
        step(0, 4'b1010, 0, 1, 1, 1, 2'd1, 32'h0, 0);
        step(0, 4'b1010, 0, 1, 1, 1, 2'd3, 32'h0, 0);
        step(0, 4'b1010, 0, 1, 1, 1, 2'd1, 32'h4, 0);
        step(0, 4'b1010, 0, 1, 1, 1, 2'd3, 32'h4, 0);

        $display("[TB] held offer on tid2 survives stall and enable drop");
        step(0, 4'b0100, 0, 0, 1, 1, 2'd2, 32'h0, 0);
        step(0, 4'b1011, 1, 0, 1, 1, 2'd2, 32'h0, 0);
        step(0, 4'b1011, 1, 0, 1, 1, 2'd2, 32'h0, 0);
        step(0, 4'b1011, 1, 1, 1, 1, 2'd2, 32'h0, 0);
        step(0, 4'b1011, 0, 1, 1, 1, 2'd3, 32'h8, 0);

        $display("[TB] redirect flushes held offer");
        step(0, 4'b0010, 0, 0, 1, 1, 2'd1, 32'h8, 0);
        stepEvt(4'b0010, 0, 0, 1, 2'd1, 32'h100, 0, 2'd0, 1, 1, 2'd1, 32'h8, 0);
        step(0, 4'b0010, 0, 1, 1, 1, 2'd1, 32'h100, 0);
        step(0, 4'b0010, 0, 1, 1, 1, 2'd1, 32'h104, 0);

        $display("[TB] exception priority and misaligned redirect");
        stepEvt(4'b0001, 0, 1, 1, 2'd0, 32'h40, 1, 2'd0, 1, 1, 2'd0, 32'h0, 0);
        stepEvt(4'b0001, 0, 1, 1, 2'd2, 32'h43, 1, 2'd3, 1, 1, 2'd0, EXC, 0);
        step(0, 4'b0100, 0, 1, 1, 1, 2'd2, 32'h40, 1);
        step(0, 4'b1000, 0, 1, 1, 1, 2'd3, EXC, 0);

        $display("[TB] PC wrap and reset during hold");
        stepEvt(4'b0000, 0, 1, 1, 2'd1, 32'hFFFF_FFFC, 0, 2'd0, 0, 0, 2'd0, 32'h0, 0);
        step(0, 4'b0010, 0, 1, 1, 1, 2'd1, 32'hFFFF_FFFC, 0);
        step(0, 4'b0010, 0, 0, 1, 1, 2'd1, 32'h0, 0);
        step(1, 4'b0010, 0, 0, 0, 0, 2'd0, 32'h0, 0);
        step(0, 4'b0100, 1, 0, 0, 0, 2'd0, 32'h0, 0);
        step(0, 4'b1111, 0, 1, 1, 1, 2'd0, 32'h0, 0);

        cmp("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
